// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller.
package mc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam int unsigned OP_LW   = 10;
    localparam int unsigned OP_SW   = 11;
    localparam int unsigned OP_BEQ  = 12;
    localparam int unsigned OP_ADDI = 13;
    localparam int unsigned OP_ILL  = 14;
    localparam int unsigned OP_HALT = 15;

    localparam int unsigned ALU_ADD = 1;

endpackage

// File: rtl/mc_decode.sv
// Instruction field extraction and immediate sign-extension.
module mc_decode #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 2,
    parameter int unsigned OP_W   = 4
) (
    input  logic [DATA_W-1:0] instr_i,
    output logic [OP_W-1:0]   opcode_o,
    output logic [RA_W-1:0]   rd_o,
    output logic [RA_W-1:0]   rs_o,
    output logic [RA_W-1:0]   rt_o,
    output logic [DATA_W-1:0] imm_o
);

    logic unused_bits;

    assign opcode_o = instr_i[DATA_W-1 -: OP_W];
    assign rd_o     = instr_i[DATA_W-OP_W-1 -: RA_W];
    assign rs_o     = instr_i[DATA_W-OP_W-RA_W-1 -: RA_W];
    assign rt_o     = instr_i[DATA_W-OP_W-2*RA_W-1 -: RA_W];
    assign imm_o    = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};

    // Gap between the register fields and the immediate carries no meaning.
    assign unused_bits = ^instr_i[DATA_W-OP_W-3*RA_W-1:16];

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control: fetch/decode/execute/memory/writeback sequencing
// around an external register file, ALU and memories.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RA_W    = 2,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [DATA_W-1:0] pc_o,
    input  logic [DATA_W-1:0] instr_i,
    output logic [DATA_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              op2en_o,
    output logic              op2rw_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [RA_W-1:0]   src1_o,
    output logic [RA_W-1:0]   src2_o,
    input  logic [DATA_W-1:0] rdata1_i,
    input  logic [DATA_W-1:0] rdata2_i,
    output logic              reg_we_o,
    output logic [RA_W-1:0]   reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              busy_o,
    output logic              halted_o,
    output logic              err_o,
    output logic [15:0]       retired_o
);

    localparam int unsigned CNT_W = 4;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        retired_q, retired_d;
    logic               err_q, err_d;

    logic [OP_W-1:0]    opcode;
    logic [RA_W-1:0]    rd, rs, rt;
    logic [DATA_W-1:0]  imm;
    logic               last_cnt, is_alu, is_sw;

    mc_decode #(
        .DATA_W(DATA_W),
        .RA_W  (RA_W),
        .OP_W  (OP_W)
    ) u_decode (
        .instr_i (ir_q),
        .opcode_o(opcode),
        .rd_o    (rd),
        .rs_o    (rs),
        .rt_o    (rt),
        .imm_o   (imm)
    );

    assign last_cnt  = (cnt_q == CNT_W'(MEM_LAT - 1));
    assign is_alu    = (opcode < OP_W'(OP_LW));
    assign is_sw     = (opcode == OP_W'(OP_SW));
    assign pc_o      = pc_q;
    assign retired_o = retired_q;
    assign err_o     = err_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        retired_d   = retired_q;
        err_d       = err_q;
        addr_o      = '0;
        wdata_o     = '0;
        op2en_o     = 1'b0;
        op2rw_o     = 1'b0;
        src1_o      = '0;
        src2_o      = '0;
        reg_we_o    = 1'b0;
        reg_waddr_o = '0;
        reg_wdata_o = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_op_o    = '0;
        busy_o      = (state_q != StIdle) && (state_q != StHalt);
        halted_o    = (state_q == StHalt);

        case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (last_cnt) begin
                    ir_d    = instr_i;
                    cnt_d   = '0;
                    state_d = StDecode;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDecode: begin
                src1_o  = rs;
                src2_o  = rt;
                a_d     = rdata1_i;
                b_d     = rdata2_i;
                state_d = StExec;
            end
            StExec: begin
                if (is_alu) begin
                    alu_a_o  = a_q;
                    alu_b_o  = b_q;
                    alu_op_o = opcode;
                    res_d    = alu_res_i;
                    state_d  = StWb;
                end else if (opcode == OP_W'(OP_ADDI)) begin
                    alu_a_o  = a_q;
                    alu_b_o  = imm;
                    alu_op_o = OP_W'(ALU_ADD);
                    res_d    = alu_res_i;
                    state_d  = StWb;
                end else if (opcode == OP_W'(OP_LW) || is_sw) begin
                    res_d   = a_q + imm;
                    cnt_d   = '0;
                    state_d = StMem;
                end else if (opcode == OP_W'(OP_BEQ)) begin
                    pc_d      = (a_q == b_q) ? pc_q + DATA_W'(1) + imm : pc_q + DATA_W'(1);
                    retired_d = retired_q + 16'd1;
                    cnt_d     = '0;
                    state_d   = StFetch;
                end else if (opcode == OP_W'(OP_HALT)) begin
                    retired_d = retired_q + 16'd1;
                    state_d   = StHalt;
                end else begin
                    // Opcode 0xE and anything undefined stop the machine with an error.
                    err_d   = 1'b1;
                    state_d = StHalt;
                end
            end
            StMem: begin
                op2en_o = 1'b1;
                addr_o  = res_q;
                if (last_cnt) begin
                    cnt_d = '0;
                    if (is_sw) begin
                        op2rw_o   = 1'b1;
                        wdata_o   = b_q;
                        pc_d      = pc_q + DATA_W'(1);
                        retired_d = retired_q + 16'd1;
                        state_d   = StFetch;
                    end else begin
                        res_d   = rdata_i;
                        state_d = StWb;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWb: begin
                reg_we_o    = 1'b1;
                reg_waddr_o = rd;
                reg_wdata_o = res_q;
                pc_d        = pc_q + DATA_W'(1);
                retired_d   = retired_q + 16'd1;
                cnt_d       = '0;
                state_d     = StFetch;
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase

        // Reset is synchronous, so the strobes must be suppressed combinationally
        // to keep an aborted instruction from writing in the reset cycle.
        if (!rst_n) begin
            op2en_o  = 1'b0;
            op2rw_o  = 1'b0;
            reg_we_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

endmodule
